// File: rtl/proc_check_pkg.sv
// Shared types and widths for the processor run checker and its watchdog.
package proc_check_pkg;

    localparam int PC_W   = 64;
    localparam int WDOG_W = 16;
    localparam int CNT_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        RST_CPU,
        RUN,
        DONE,
        TIMEOUT
    } state_t;

endpackage

// File: rtl/proc_watchdog.sv
// Saturating run-cycle counter; expired flags that the count has reached the limit.
module proc_watchdog
    import proc_check_pkg::*;
(
    input  logic              CLK,
    input  logic              reset,
    input  logic              clear,
    input  logic              enable,
    input  logic [WDOG_W-1:0] limit,
    output logic              expired
);

    logic [WDOG_W-1:0] count;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != limit)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == limit);

endmodule

// File: rtl/proc_run_checker.sv
// Run controller for the single-cycle core: resets it, runs it, and scores each
// checkpoint (PC reached -> compare writeback value) under a watchdog.
module proc_run_checker
    import proc_check_pkg::*;
#(
    parameter int                NUM_TESTS  = 2,
    parameter logic [PC_W-1:0]   START_PC   = 64'h0,
    parameter int                RST_CYCLES = 2,
    parameter logic [WDOG_W-1:0] WDOG_LIMIT = 16'h00FF
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic                      start,
    input  logic [PC_W*NUM_TESTS-1:0] chk_endpc,
    input  logic [PC_W*NUM_TESTS-1:0] chk_expect,
    input  logic [PC_W-1:0]           currentpc,
    input  logic [PC_W-1:0]           MemtoRegOut,
    output logic                      cpu_resetl,
    output logic [PC_W-1:0]           cpu_startpc,
    output logic                      busy,
    output logic                      done,
    output logic                      all_pass,
    output logic [CNT_W-1:0]          pass_count,
    output logic [NUM_TESTS-1:0]      fail_vec,
    output logic                      wdog_expired
);

    localparam int IDX_W = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [15:0]        rst_cnt;
    logic [PC_W-1:0]    endpc_cur;
    logic [PC_W-1:0]    expect_cur;
    logic               hit;
    logic               match;
    logic               last;
    logic               wdog_hit;
    logic               start_ok;
    logic [CNT_W-1:0]   pass_nxt;
    logic [NUM_TESTS-1:0] fail_chk;
    logic [NUM_TESTS-1:0] mask_from;
    logic [NUM_TESTS-1:0] mask_after;

    assign endpc_cur  = chk_endpc[int'(idx)*PC_W +: PC_W];
    assign expect_cur = chk_expect[int'(idx)*PC_W +: PC_W];
    assign hit        = (currentpc >= endpc_cur);
    assign match      = (MemtoRegOut == expect_cur);
    assign last       = (idx == IDX_W'(NUM_TESTS - 1));
    assign pass_nxt   = pass_count + CNT_W'(match);
    assign start_ok   = start && ((state == IDLE) || (state == DONE) || (state == TIMEOUT));

    // fail_chk folds in the current checkpoint; the masks mark tests left unchecked on abort
    always_comb begin
        fail_chk   = fail_vec;
        mask_from  = '0;
        mask_after = '0;
        for (int i = 0; i < NUM_TESTS; i++) begin
            fail_chk[i]   = fail_vec[i] | (!match && (i == int'(idx)));
            mask_from[i]  = (i >= int'(idx));
            mask_after[i] = (i > int'(idx));
        end
    end

    proc_watchdog u_wdog (
        .CLK     (CLK),
        .reset   (reset),
        .clear   (start_ok),
        .enable  (state == RUN),
        .limit   (WDOG_LIMIT),
        .expired (wdog_hit)
    );

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cpu_resetl   <= 1'b0;
            cpu_startpc  <= START_PC;
            busy         <= 1'b0;
            done         <= 1'b0;
            all_pass     <= 1'b0;
            pass_count   <= '0;
            fail_vec     <= '0;
            wdog_expired <= 1'b0;
            idx          <= '0;
            rst_cnt      <= '0;
        end else begin
            cpu_startpc <= START_PC;
            case (state)
                IDLE, DONE, TIMEOUT: begin
                    if (start) begin
                        state        <= RST_CPU;
                        cpu_resetl   <= 1'b0;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        all_pass     <= 1'b0;
                        pass_count   <= '0;
                        fail_vec     <= '0;
                        wdog_expired <= 1'b0;
                        idx          <= '0;
                        rst_cnt      <= '0;
                    end
                end
                RST_CPU: begin
                    if (rst_cnt == 16'(RST_CYCLES - 1)) begin
                        state      <= RUN;
                        cpu_resetl <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (hit) begin
                        pass_count <= pass_nxt;
                        if (last) begin
                            state      <= DONE;
                            fail_vec   <= fail_chk;
                            done       <= 1'b1;
                            busy       <= 1'b0;
                            cpu_resetl <= 1'b0;
                            all_pass   <= (pass_nxt == CNT_W'(NUM_TESTS));
                        end else if (wdog_hit) begin
                            state        <= TIMEOUT;
                            fail_vec     <= fail_chk | mask_after;
                            wdog_expired <= 1'b1;
                            done         <= 1'b1;
                            busy         <= 1'b0;
                            cpu_resetl   <= 1'b0;
                        end else begin
                            fail_vec <= fail_chk;
                            idx      <= idx + 1'b1;
                        end
                    end else if (wdog_hit) begin
                        state        <= TIMEOUT;
                        fail_vec     <= fail_vec | mask_from;
                        wdog_expired <= 1'b1;
                        done         <= 1'b1;
                        busy         <= 1'b0;
                        cpu_resetl   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
